avalon_mm_master_seq: RTL and testbench
=======================================

// Module: avalon_mm_master_seq
// PURPOSE
//  Hardware Avalon-MM master (initiator) for the GravSim register-file slave. It lets fabric logic
//  (keyboard/pause control, scene loader, debug readback) access body registers directly, without
//  the NIOS. Commands are queued in a small FIFO and issued one at a time, honouring waitrequest.
//  Read data is returned on a response strobe, and a waitrequest timeout flags a hung slave.
// PARAMETERS
//  DEPTH         4    command FIFO entries; power of 2, >= 2
//  READ_LATENCY  0    cycles from read acceptance to valid AVM_READDATA; 0..3 (0 = same cycle)
//  TIMEOUT       255  max consecutive cycles waitrequest may stall one command; 1..255
// PORTS
//  CLK             in   1   system clock, 50 MHz
//  RESET_N         in   1   reset, asynchronous, active-low
//  CMD_VALID       in   1   command present
//  CMD_READY       out  1   FIFO can accept; high = not full
//  CMD_WRITE       in   1   1 = write, 0 = read
//  CMD_ADDR        in   8   register word address
//  CMD_WRDATA      in   32  write data
//  CMD_BYTE_EN     in   4   byte enables (write only; reads issue 4'b1111)
//  RSP_VALID       out  1   1-cycle pulse: read data valid
//  RSP_DATA        out  32  read data; held until next RSP_VALID
//  BUSY            out  1   FIFO non-empty or FSM not in IDLE
//  ERR             out  1   sticky timeout flag
//  ERR_CLR         in   1   clears ERR
//  AVM_READ        out  1   Avalon read strobe
//  AVM_WRITE       out  1   Avalon write strobe
//  AVM_CS          out  1   chip select; high whenever a strobe is high
//  AVM_ADDR        out  8   address
//  AVM_BYTE_EN     out  4   byte enables
//  AVM_WRITEDATA   out  32  write data
//  AVM_READDATA    in   32  read data
//  AVM_WAITREQUEST in   1   slave stall; tie low for zero-wait slaves
// BEHAVIOUR
//  Reset: all outputs 0 except CMD_READY=1. FIFO empty, FSM in IDLE, counters 0, ERR=0.
//   RESET_N low mid-transaction aborts it immediately; the in-flight command and queued commands are lost.
//  FIFO: push on CMD_VALID&CMD_READY; pop when the FSM retires the head. Pointers wrap mod DEPTH.
//   A push into an empty FIFO is visible to the FSM on the next cycle.
//   A push while full is impossible (READY low). Simultaneous push and pop keeps the count.
//  FSM states IDLE, ISSUE, WAIT_DATA, RESP. All AVM_* outputs are registered.
//  IDLE: FIFO non-empty -> load head into AVM_* and assert strobe+CS -> ISSUE.
//   A command accepted at edge 0 drives its strobe from edge 2 onward.
//  ISSUE: strobe/addr/data held stable while AVM_WAITREQUEST=1; stall counter increments.
//   WAITREQUEST=0 ends acceptance: strobes drop at the next edge and the head is popped.
//   Write accepted -> IDLE.
//   Read accepted, LATENCY=0 -> capture AVM_READDATA this cycle -> RESP.
//   Read accepted, LATENCY>0 -> WAIT_DATA, with latency counter = READ_LATENCY-1.
//   Stall counter reaches TIMEOUT with WAITREQUEST still 1:
//     drop strobes, pop the command, set ERR, no RSP pulse -> IDLE.
//  WAIT_DATA: decrement; at 0, capture AVM_READDATA -> RESP.
//  RESP: RSP_VALID=1 for exactly one cycle with RSP_DATA = captured word -> IDLE.
//   There is no response backpressure.
//  Only one transaction is outstanding. Back-to-back commands have >= 1 idle cycle between strobes.
//  ERR: set on timeout, cleared by ERR_CLR. Set and clear in the same cycle -> set wins.
//  BUSY = (count != 0) | (state != IDLE).
// TESTING
//  Write 0x00000005 to addr 1, WAITREQ=0 -> one AVM_WRITE cycle:
//   ADDR=1, DATA=5, BE=F, CS=1; strobe starts 2 cycles after accept; no RSP.
//  Read addr 3, LATENCY=0, slave returns 0xDEADBEEF -> one AVM_READ cycle; RSP_VALID pulse 1 cycle later, DATA=DEADBEEF.
//  LATENCY=2, read with WAITREQ high 3 cycles -> strobe held 4 cycles, addr stable; RSP 3 cycles after acceptance.
//  Push 5 commands back-to-back, DEPTH=4 -> CMD_READY low after 4th; all 5 issued in order, no loss.
//  TIMEOUT=8, WAITREQ stuck high -> strobe drops after 8 stall cycles, ERR=1, next command proceeds; ERR_CLR -> ERR=0.
//  Assert RESET_N low during ISSUE -> strobes/CS 0 asynchronously, CMD_READY=1, BUSY=0.

Source files
------------

// File: rtl/avalon_mm_master_seq.sv
// Avalon-MM master sequencer.
// Accepts read/write commands into a small FIFO and issues them one at a
// time on an Avalon-MM master port. It honours waitrequest and handles a
// fixed read latency. Read data is returned on a single-cycle response
// strobe. A sticky error flag is raised when a slave stalls too long.
module avalon_mm_master_seq #(
  parameter int DEPTH        = 4,    // command FIFO entries, power of 2, >= 2
  parameter int READ_LATENCY = 0,    // 0..3 cycles from read acceptance to data
  parameter int TIMEOUT      = 255   // 1..255 stall cycles before giving up
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // command side
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [31:0] cmd_wrdata_i,
  input  logic [3:0]  cmd_byte_en_i,
  // response / status
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  // Avalon-MM master
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic        avm_cs_o,
  output logic [7:0]  avm_addr_o,
  output logic [3:0]  avm_byte_en_o,
  output logic [31:0] avm_writedata_o,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_waitrequest_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  // FIFO entry layout: {write, addr, wrdata, byte_en}
  localparam int EW = 1 + 8 + 32 + 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } state_e;

  state_e state_q;

  // FIFO storage and pointers
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [EW-1:0] head_q;
  logic          head_vld_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // transaction registers
  logic        avm_read_q, avm_write_q, avm_cs_q;
  logic [7:0]  avm_addr_q;
  logic [3:0]  avm_byte_en_q;
  logic [31:0] avm_writedata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [7:0]  stall_q;
  logic [1:0]  lat_q;
  logic        err_q;

  logic push;
  logic pop;
  logic timeout_hit;

  // head entry fields
  logic        head_write;
  logic [7:0]  head_addr;
  logic [31:0] head_wrdata;
  logic [3:0]  head_byte_en;

  assign {head_write, head_addr, head_wrdata, head_byte_en} = head_q;

  assign cmd_ready_o = (count_q != FULL_CNT);
  assign push        = cmd_valid_i && cmd_ready_o;
  // Timeout fires on the TIMEOUT-th consecutive stalled cycle of one command.
  assign timeout_hit = (state_q == ISSUE) && avm_waitrequest_i && (stall_q == TMO_LAST);
  // The head is retired when the slave accepts it or when it times out.
  assign pop         = (state_q == ISSUE) && (!avm_waitrequest_i || timeout_hit);

  // Next-state pointer and occupancy arithmetic for the command FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage with registered head read, kept free of reset so it maps to RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_write_i, cmd_addr_i, cmd_wrdata_i, cmd_byte_en_i};
    end
    head_q <= fifo_mem[rd_ptr_q];
  end

  // FIFO pointer/count registers; head_vld marks head_q as a fresh copy of a real entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      // Only trusted when sampled in IDLE, so a just-popped head is never reissued.
      head_vld_q <= (count_q != '0) && (state_q == IDLE);
    end
  end

  // Transaction sequencer: issue, stall/timeout handling, read latency and response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_cs_q        <= 1'b0;
      avm_addr_q      <= '0;
      avm_byte_en_q   <= '0;
      avm_writedata_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      stall_q         <= '0;
      lat_q           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (head_vld_q && (count_q != '0)) begin
            avm_addr_q      <= head_addr;
            avm_writedata_q <= head_wrdata;
            // Reads always fetch the full word.
            avm_byte_en_q   <= head_write ? head_byte_en : 4'hF;
            avm_write_q     <= head_write;
            avm_read_q      <= !head_write;
            avm_cs_q        <= 1'b1;
            stall_q         <= '0;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avm_waitrequest_i) begin
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            avm_cs_q    <= 1'b0;
            if (avm_write_q) begin
              state_q <= IDLE;
            end else if (READ_LATENCY == 0) begin
              rsp_data_q  <= avm_readdata_i;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              lat_q   <= LAT_INIT;
              state_q <= WAIT_DATA;
            end
          end else if (timeout_hit) begin
            // Abandon the command silently; only the error flag records it.
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            avm_cs_q    <= 1'b0;
            state_q     <= IDLE;
          end else begin
            stall_q <= stall_q + 8'd1;
          end
        end
        WAIT_DATA: begin
          if (lat_q == 2'd0) begin
            rsp_data_q  <= avm_readdata_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout takes priority over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign avm_read_o      = avm_read_q;
  assign avm_write_o     = avm_write_q;
  assign avm_cs_o        = avm_cs_q;
  assign avm_addr_o      = avm_addr_q;
  assign avm_byte_en_o   = avm_byte_en_q;
  assign avm_writedata_o = avm_writedata_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign err_o           = err_q;
  assign busy_o          = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_avalon_mm_master_seq.sv
// Testbench for avalon_mm_master_seq.
// Instance u_dut: READ_LATENCY=0, TIMEOUT=8, with a scoreboard of expected
// Avalon transfers and responses. Instance u_dut_l2: READ_LATENCY=2, used
// for the latency/stall step.
module tb_avalon_mm_master_seq;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 1 signals
  logic        c_valid = 1'b0, c_write = 1'b0, err_clr = 1'b0, a_wait = 1'b0;
  logic [7:0]  c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic [3:0]  c_be = '0;
  logic        c_ready, r_valid, busy, err, a_read, a_write, a_cs;
  logic [31:0] r_data, a_wdata, a_rdata;
  logic [7:0]  a_addr;
  logic [3:0]  a_be;

  // instance 2 signals
  logic        c2_valid = 1'b0, a2_wait = 1'b1;
  logic [7:0]  c2_addr = '0;
  logic        c2_ready, r2_valid, busy2, err2, a2_read, a2_write, a2_cs;
  logic [31:0] r2_data, a2_wdata, a2_rdata;
  logic [7:0]  a2_addr;
  logic [3:0]  a2_be;

  xfer_t       sb_q[$];
  logic [31:0] rsp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] rd_val(input logic [7:0] a);
    return 32'hDEADBEEF ^ {24'h0, a ^ 8'h03};
  endfunction

  avalon_mm_master_seq #(.DEPTH(4), .READ_LATENCY(0), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(c_valid), .cmd_ready_o(c_ready), .cmd_write_i(c_write),
    .cmd_addr_i(c_addr), .cmd_wrdata_i(c_wdata), .cmd_byte_en_i(c_be),
    .rsp_valid_o(r_valid), .rsp_data_o(r_data), .busy_o(busy), .err_o(err),
    .err_clr_i(err_clr),
    .avm_read_o(a_read), .avm_write_o(a_write), .avm_cs_o(a_cs),
    .avm_addr_o(a_addr), .avm_byte_en_o(a_be), .avm_writedata_o(a_wdata),
    .avm_readdata_i(a_rdata), .avm_waitrequest_i(a_wait)
  );

  avalon_mm_master_seq #(.DEPTH(4), .READ_LATENCY(2), .TIMEOUT(255)) u_dut_l2 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(c2_valid), .cmd_ready_o(c2_ready), .cmd_write_i(1'b0),
    .cmd_addr_i(c2_addr), .cmd_wrdata_i(32'h0), .cmd_byte_en_i(4'h0),
    .rsp_valid_o(r2_valid), .rsp_data_o(r2_data), .busy_o(busy2), .err_o(err2),
    .err_clr_i(1'b0),
    .avm_read_o(a2_read), .avm_write_o(a2_write), .avm_cs_o(a2_cs),
    .avm_addr_o(a2_addr), .avm_byte_en_o(a2_be), .avm_writedata_o(a2_wdata),
    .avm_readdata_i(a2_rdata), .avm_waitrequest_i(a2_wait)
  );

  // Zero-latency slave: data valid in the accepting cycle only.
  assign a_rdata = (a_read && !a_wait) ? rd_val(a_addr) : 32'h0BAD0BAD;

  // Two-cycle-latency slave: data valid only in the second cycle after acceptance.
  logic       s1 = 1'b0, s2 = 1'b0;
  logic [7:0] s1_addr = '0, s2_addr = '0;
  always @(posedge clk) begin
    s1      <= a2_read && !a2_wait;
    s1_addr <= a2_addr;
    s2      <= s1;
    s2_addr <= s1_addr;
  end
  assign a2_rdata = s2 ? rd_val(s2_addr) : 32'h0BAD0BAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    c_valid = 1'b1;
    c_write = wr;
    c_addr  = addr;
    c_wdata = data;
    c_be    = be;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  // Scoreboard monitor: every accepted Avalon transfer must match the queue head.
  always @(negedge clk) begin
    if (rst_n && (a_read || a_write) && !a_wait) begin
      if (sb_q.size() == 0) begin
        check("avm_unexpected", {24'h0, a_addr}, 32'hFFFFFFFF);
      end else begin
        xfer_t e;
        e = sb_q.pop_front();
        check("avm_wr", {31'h0, a_write}, {31'h0, e.wr});
        check("avm_rd", {31'h0, a_read}, {31'h0, !e.wr});
        check("avm_cs", {31'h0, a_cs}, 32'h1);
        check("avm_addr", {24'h0, a_addr}, {24'h0, e.addr});
        check("avm_be", {28'h0, a_be}, {28'h0, e.be});
        if (e.wr) check("avm_wdata", a_wdata, e.data);
      end
    end
  end

  // Response monitor: every RSP pulse must match the next expected read word.
  always @(negedge clk) begin
    if (rst_n && r_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", r_data, 32'hFFFFFFFF);
      end else begin
        logic [31:0] e;
        e = rsp_q.pop_front();
        check("rsp_data", r_data, e);
      end
    end
  end

  initial begin
    logic was_ready;
    int   n;

    // ---- reset state ----
    tick(); tick();
    check("rst_ready", {31'h0, c_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_strobes", {29'h0, a_read, a_write, a_cs}, 32'h0);
    check("rst_rsp", {31'h0, r_valid}, 32'h0);
    rst_n = 1'b1;
    tick();

    // ---- single write, zero wait ----
    drive_cmd(1'b1, 8'h01, 32'h00000005, 4'hF);
    sb_q.push_back('{wr: 1'b1, addr: 8'h01, data: 32'h5, be: 4'hF});
    tick();                                   // edge 0: accepted
    c_valid = 1'b0;
    check("wr_e0", {31'h0, a_write}, 32'h0);
    tick();                                   // edge 1
    check("wr_e1", {31'h0, a_write}, 32'h0);
    check("wr_busy", {31'h0, busy}, 32'h1);
    tick();                                   // edge 2: strobe
    check("wr_e2_strobe", {31'h0, a_write}, 32'h1);
    check("wr_e2_cs", {31'h0, a_cs}, 32'h1);
    check("wr_e2_addr", {24'h0, a_addr}, 32'h1);
    check("wr_e2_data", a_wdata, 32'h5);
    check("wr_e2_be", {28'h0, a_be}, 32'hF);
    tick();                                   // edge 3: dropped
    check("wr_e3_drop", {31'h0, a_write}, 32'h0);
    check("wr_no_rsp", {31'h0, r_valid}, 32'h0);
    wait_idle("wr_idle");

    // ---- single read, latency 0 ----
    drive_cmd(1'b0, 8'h03, 32'h0, 4'h0);
    sb_q.push_back('{wr: 1'b0, addr: 8'h03, data: 32'h0, be: 4'hF});
    rsp_q.push_back(32'hDEADBEEF);
    tick();                                   // edge 0
    c_valid = 1'b0;
    tick();                                   // edge 1
    check("rd_e1", {31'h0, a_read}, 32'h0);
    tick();                                   // edge 2
    check("rd_e2_strobe", {31'h0, a_read}, 32'h1);
    check("rd_e2_be", {28'h0, a_be}, 32'hF);
    tick();                                   // edge 3
    check("rd_e3_drop", {31'h0, a_read}, 32'h0);
    check("rd_e3_rsp", {31'h0, r_valid}, 32'h1);
    check("rd_e3_data", r_data, 32'hDEADBEEF);
    tick();                                   // edge 4
    check("rd_e4_pulse", {31'h0, r_valid}, 32'h0);
    check("rd_e4_hold", r_data, 32'hDEADBEEF);
    check("rd_e4_busy", {31'h0, busy}, 32'h0);

    // ---- latency 2, waitrequest high for 3 cycles ----
    a2_wait  = 1'b1;
    c2_valid = 1'b1;
    c2_addr  = 8'h07;
    tick();                                   // edge 0
    c2_valid = 1'b0;
    tick();                                   // edge 1
    tick();                                   // edge 2
    check("l2_e2_strobe", {31'h0, a2_read}, 32'h1);
    check("l2_e2_addr", {24'h0, a2_addr}, 32'h7);
    tick();                                   // edge 3
    check("l2_e3_strobe", {31'h0, a2_read}, 32'h1);
    tick();                                   // edge 4
    check("l2_e4_strobe", {31'h0, a2_read}, 32'h1);
    tick();                                   // edge 5
    check("l2_e5_strobe", {31'h0, a2_read}, 32'h1);
    check("l2_e5_addr", {24'h0, a2_addr}, 32'h7);
    a2_wait = 1'b0;
    tick();                                   // edge 6: accepted
    check("l2_e6_drop", {31'h0, a2_read}, 32'h0);
    tick();                                   // edge 7
    check("l2_e7_norsp", {31'h0, r2_valid}, 32'h0);
    tick();                                   // edge 8
    check("l2_e8_rsp", {31'h0, r2_valid}, 32'h1);
    check("l2_e8_data", r2_data, 32'hDEADBEEB);
    tick();                                   // edge 9
    check("l2_e9_pulse", {31'h0, r2_valid}, 32'h0);
    check("l2_busy", {31'h0, busy2}, 32'h0);

    // ---- five back-to-back commands into a 4-deep FIFO ----
    a_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, 8'h10 + 8'(i), 32'hC0DE0000 | i, 4'hF ^ 4'(i));
      sb_q.push_back('{wr: 1'b1, addr: 8'h10 + 8'(i), data: 32'hC0DE0000 | i, be: 4'hF ^ 4'(i)});
      n = 0;
      do begin
        was_ready = c_ready;
        tick();
        n++;
      end while (!was_ready && n < 50);
      check("b2b_accept", {31'h0, was_ready}, 32'h1);
      if (i == 3) begin
        check("b2b_full", {31'h0, c_ready}, 32'h0);
        a_wait = 1'b0;
      end
    end
    c_valid = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_sb_empty", sb_q.size(), 32'h0);

    // ---- timeout with waitrequest stuck, next command proceeds ----
    a_wait = 1'b1;
    drive_cmd(1'b1, 8'h20, 32'h12345678, 4'hF);
    tick();                                   // edge 0
    drive_cmd(1'b0, 8'h21, 32'h0, 4'h0);
    sb_q.push_back('{wr: 1'b0, addr: 8'h21, data: 32'h0, be: 4'hF});
    rsp_q.push_back(32'hDEADBECD);
    tick();                                   // edge 1
    c_valid = 1'b0;
    tick();                                   // edge 2
    check("to_e2_strobe", {31'h0, a_write}, 32'h1);
    check("to_e2_addr", {24'h0, a_addr}, 32'h20);
    repeat (7) tick();                        // edge 9
    check("to_e9_strobe", {31'h0, a_write}, 32'h1);
    check("to_e9_err", {31'h0, err}, 32'h0);
    tick();                                   // edge 10
    check("to_e10_drop", {31'h0, a_write}, 32'h0);
    check("to_e10_cs", {31'h0, a_cs}, 32'h0);
    check("to_e10_err", {31'h0, err}, 32'h1);
    a_wait = 1'b0;
    wait_idle("to_idle");
    check("to_err_sticky", {31'h0, err}, 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", {31'h0, err}, 32'h0);

    // ---- asynchronous reset during ISSUE ----
    a_wait = 1'b1;
    drive_cmd(1'b1, 8'h30, 32'hAAAA5555, 4'hF);
    tick();                                   // edge 0
    drive_cmd(1'b1, 8'h31, 32'h5555AAAA, 4'hF);
    tick();                                   // edge 1
    c_valid = 1'b0;
    tick();                                   // edge 2
    check("ar_strobe", {31'h0, a_write}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_strobes", {29'h0, a_read, a_write, a_cs}, 32'h0);
    check("ar_ready", {31'h0, c_ready}, 32'h1);
    check("ar_busy", {31'h0, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    a_wait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_no_replay", {31'h0, a_write}, 32'h0);
    end

    // ---- recovery write after reset ----
    drive_cmd(1'b1, 8'h40, 32'hFEEDF00D, 4'h6);
    sb_q.push_back('{wr: 1'b1, addr: 8'h40, data: 32'hFEEDF00D, be: 4'h6});
    tick();
    c_valid = 1'b0;
    wait_idle("post_idle");
    tick();

    check("end_sb_empty", sb_q.size(), 32'h0);
    check("end_rsp_empty", rsp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
